// File: rtl/core_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the code-fetch and data ports: gnt+mem_en one cycle after the request, done MEM_LATENCY+1 cycles later.
// Ties go round-robin by default; define ARB_DATA_PRIORITY_EN to make the data port win every tie.
module core_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_stop,
  input  logic              code_req,
  input  logic [ADDR_W-1:0] code_addr,
  output logic              code_gnt,
  output logic              code_done,
  output logic [DATA_W-1:0] code_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t      state;
  logic        last_data;
  logic        owner_data;
  logic [3:0]  cnt;
  logic        pick_data;

  always_comb begin
    pick_data = 1'b0;
`ifdef ARB_DATA_PRIORITY_EN
    pick_data = data_req;
`else
    // on a tie the port that did not win last time gets the memory
    pick_data = data_req && (!code_req || !last_data);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_data  <= 1'b1;
      owner_data <= 1'b0;
      cnt        <= '0;
      code_gnt   <= 1'b0;
      code_done  <= 1'b0;
      code_rdata <= '0;
      data_gnt   <= 1'b0;
      data_done  <= 1'b0;
      data_rdata <= '0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      code_gnt  <= 1'b0;
      data_gnt  <= 1'b0;
      code_done <= 1'b0;
      data_done <= 1'b0;
      mem_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (!core_stop && (code_req || data_req)) begin
            owner_data <= pick_data;
            code_gnt   <= !pick_data;
            data_gnt   <= pick_data;
            mem_en     <= 1'b1;
            mem_rw     <= pick_data && data_we;
            mem_addr   <= pick_data ? data_addr : code_addr;
            mem_wdata  <= pick_data ? data_wdata : '0;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= 4'(MEM_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            // mem_rdata is valid in this cycle only
            if (owner_data) begin
              data_done <= 1'b1;
              if (!mem_rw) data_rdata <= mem_rdata;
            end else begin
              code_done  <= 1'b1;
              code_rdata <= mem_rdata;
            end
            last_data <= owner_data;
            busy      <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios then random transactions against a transaction-level model.
module tb_core_mem_arbiter;
  localparam int L = 2;
  localparam int P = L + 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_stop;
  logic        code_req;
  logic [31:0] code_addr;
  logic        code_gnt, code_done;
  logic [31:0] code_rdata;
  logic        data_req, data_we;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_done;
  logic [31:0] data_rdata;
  logic        mem_en, mem_rw;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int tests = 0;
  int failed = 0;

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .core_stop(core_stop),
    .code_req(code_req), .code_addr(code_addr), .code_gnt(code_gnt),
    .code_done(code_done), .code_rdata(code_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_done(data_done),
    .data_rdata(data_rdata), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // memory: fixed latency, data present only in the exact valid cycle
  logic [31:0] mem [256];
  bit          wr_ok [256];
  int          pend_cnt = 0;
  logic [31:0] pend_val = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) begin
        mem[mem_addr[7:0]]   <= mem_wdata;
        wr_ok[mem_addr[7:0]] <= 1'b1;
      end
      pend_val <= wr_ok[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
      pend_cnt <= L;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end
  assign mem_rdata = (pend_cnt == 1) ? pend_val : 32'hBADC0FFE;

  // reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] ref_code_rdata = '0;
  logic [31:0] ref_data_rdata = '0;
  bit          ref_last_data = 1'b1;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int k;
    k = int'(a[7:0]);
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_val(a[7:0]);
  endfunction

  function automatic bit pick(input bit c, input bit d);
`ifdef ARB_DATA_PRIORITY_EN
    return d;
`else
    if (c && d) return !ref_last_data;
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ref_reset;
    ref_code_rdata = '0;
    ref_data_rdata = '0;
    ref_last_data  = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, {28'd0, code_gnt, data_gnt, code_done, data_done}, 32'd0);
    chk({tag, "_mem_en_rw_busy"}, {29'd0, mem_en, mem_rw, busy}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_code_rdata"}, code_rdata, 32'd0);
    chk({tag, "_data_rdata"}, data_rdata, 32'd0);
  endtask

  // requests already driven; checks one whole access from grant to done
  task automatic expect_txn(input bit w, input bit stop_mid);
    logic [31:0] a, wd;
    logic        we;
    a  = w ? data_addr : code_addr;
    we = w ? data_we : 1'b0;
    wd = data_wdata;
    tick;
    chk("code_gnt", code_gnt, !w);
    chk("data_gnt", data_gnt, w);
    chk("mem_en", mem_en, 1);
    chk("mem_rw", mem_rw, we);
    chk("mem_addr", mem_addr, a);
    if (we) chk("mem_wdata", mem_wdata, wd);
    chk("busy_acc", busy, 1);
    chk("done_acc", {code_done, data_done}, 0);
    code_req = 1'b0;
    data_req = 1'b0;
    if (stop_mid) core_stop = 1'b1;
    for (int k = 2; k <= L + 1; k++) begin
      tick;
      chk("wait_pulses", {mem_en, code_gnt, data_gnt, code_done, data_done}, 0);
      chk("wait_busy", busy, 1);
      chk("wait_addr_hold", mem_addr, a);
    end
    tick;
    if (we) ref_mem[int'(a[7:0])] = wd;
    else if (w) ref_data_rdata = ref_read(a);
    else ref_code_rdata = ref_read(a);
    ref_last_data = w;
    chk("code_done", code_done, !w);
    chk("data_done", data_done, w);
    chk("busy_done", busy, 0);
    chk("code_rdata", code_rdata, ref_code_rdata);
    chk("data_rdata", data_rdata, ref_data_rdata);
    core_stop = 1'b0;
  endtask

  initial begin
    bit w;
    bit cur_w;
    reset_n = 1'b0; core_stop = 1'b0;
    code_req = 1'b0; code_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    tick; tick;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick;
    chk_all_zero("post_reset_idle");

    // code read of 0x10
    code_req = 1'b1; code_addr = 32'h10;
    expect_txn(pick(1, 0), 0);
    chk("code_deadbeef", code_rdata, 32'hDEADBEEF);

    // data write of 0x40
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'h12345678;
    expect_txn(pick(0, 1), 0);
    data_we = 1'b0;

    // read back the written word
    data_req = 1'b1; data_addr = 32'h40;
    expect_txn(pick(0, 1), 0);
    chk("readback", data_rdata, 32'h12345678);

    // both requests held from reset
    reset_n = 1'b0; code_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
    code_addr = 32'h10; data_addr = 32'h40;
    ref_reset();
    tick; tick;
    reset_n = 1'b1;
    cur_w = 1'b0;
    for (int c = 1; c <= 4 * P; c++) begin
      tick;
      if ((c - 1) % P == 0) begin
        cur_w = pick(1, 1);
        chk("tie_code_gnt", code_gnt, !cur_w);
        chk("tie_data_gnt", data_gnt, cur_w);
      end else begin
        chk("tie_no_gnt", {code_gnt, data_gnt}, 0);
      end
      if (c % P == 0) begin
        if (cur_w) ref_data_rdata = ref_read(data_addr);
        else ref_code_rdata = ref_read(code_addr);
        ref_last_data = cur_w;
        chk("tie_done", {code_done, data_done}, {30'd0, !cur_w, cur_w});
        chk("tie_code_rdata", code_rdata, ref_code_rdata);
        chk("tie_data_rdata", data_rdata, ref_data_rdata);
      end
      if (c == 4 * P) begin
        code_req = 1'b0;
        data_req = 1'b0;
      end
    end
    tick;
    chk("tie_end_idle", {code_gnt, data_gnt, busy}, 0);

    // core_stop blocks grants
    core_stop = 1'b1; code_req = 1'b1; code_addr = 32'h33;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("stop_no_gnt", {code_gnt, data_gnt, mem_en, busy}, 0);
    end
    core_stop = 1'b0;
    expect_txn(pick(1, 0), 0);

    // core_stop raised in the mem_en cycle of a data read
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h10;
    expect_txn(pick(0, 1), 1);
    chk("stop_mid_data", data_rdata, 32'hDEADBEEF);

    // reset during WAIT of a code read
    code_req = 1'b1; code_addr = 32'h20;
    expect_txn(pick(1, 0), 0);
    code_req = 1'b1; code_addr = 32'h24;
    tick;
    chk("rst_pre_gnt", code_gnt, 1);
    code_req = 1'b0;
    tick;
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    ref_reset();
    tick;
    reset_n = 1'b1;
    for (int c = 0; c < L + 3; c++) begin
      tick;
      chk("no_done_after_rst", {code_done, data_done, busy}, 0);
    end
    code_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
    code_addr = 32'h44; data_addr = 32'h48;
    w = pick(1, 1);
`ifndef ARB_DATA_PRIORITY_EN
    chk("first_tie_is_code", w, 0);
`endif
    expect_txn(w, 0);

    // random transactions
    for (int i = 0; i < 200; i++) begin
      core_stop  = ($urandom_range(0, 3) == 0);
      code_req   = 1'($urandom_range(0, 1));
      data_req   = 1'($urandom_range(0, 1));
      code_addr  = 32'($urandom_range(0, 255));
      data_addr  = 32'($urandom_range(0, 255));
      data_we    = 1'($urandom_range(0, 1));
      data_wdata = $urandom;
      if (core_stop || !(code_req || data_req)) begin
        tick;
        chk("rnd_idle", {code_gnt, data_gnt, mem_en, busy}, 0);
      end else begin
        expect_txn(pick(code_req, data_req), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
